rrf_freelist_mp: RTL and testbench

- Parametrised, multi-port rename register file with an integrated circular free-list allocator.
- Replaces the fixed two-writer rename file in the DP stage. Allocates up to 2 entries per cycle in program order and frees up to 2 per cycle at commit.
- Accepts writeback from WB_PORTS execution units and serves RD_PORTS source-operand reads with same-cycle writeback bypass.
- Provides oldest-entry data to the commit path and supports a full speculative flush.

---
 rtl/rrf_freelist_mp.sv | 142 ++++++++++++++
 tb/tb_rrf_freelist_mp.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rrf_freelist_mp.sv
// Rename register file with an integrated circular free-list allocator.
// Up to 2 in-order allocations per cycle at tail and 2 commits per cycle at head.
// WB_PORTS writeback ports and RD_PORTS source-operand read ports.
// Read ports bypass same-cycle writebacks.
// Ports:
//   clk_i, reset_n_i              clock, async active-low reset
//   alloc_num_i/alloc_stall_o     allocation request and refusal
//   alloc_tag0_o/alloc_tag1_o     granted tags (tail, tail+1)
//   free_cnt_o                    number of free entries
//   wb_we_i/wb_tag_i/wb_data_i    packed writeback ports
//   rd_tag_i/rd_data_o/rd_valid_o packed read ports
//   com_num_i/com_data*_o/com_valid_o  commit count and head/head+1 data
//   flush_i                       discard all uncommitted allocations
module rrf_freelist_mp #(
  parameter int unsigned RRF_NUM  = 64,
  parameter int unsigned RRF_SEL  = $clog2(RRF_NUM),
  parameter int unsigned DATA_LEN = 32,
  parameter int unsigned WB_PORTS = 5,
  parameter int unsigned RD_PORTS = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [1:0]                   alloc_num_i,
  output logic                         alloc_stall_o,
  output logic [RRF_SEL-1:0]           alloc_tag0_o,
  output logic [RRF_SEL-1:0]           alloc_tag1_o,
  output logic [RRF_SEL:0]             free_cnt_o,
  input  logic [WB_PORTS-1:0]          wb_we_i,
  input  logic [WB_PORTS*RRF_SEL-1:0]  wb_tag_i,
  input  logic [WB_PORTS*DATA_LEN-1:0] wb_data_i,
  input  logic [RD_PORTS*RRF_SEL-1:0]  rd_tag_i,
  output logic [RD_PORTS*DATA_LEN-1:0] rd_data_o,
  output logic [RD_PORTS-1:0]          rd_valid_o,
  input  logic [1:0]                   com_num_i,
  output logic [DATA_LEN-1:0]          com_data0_o,
  output logic [DATA_LEN-1:0]          com_data1_o,
  output logic [1:0]                   com_valid_o,
  input  logic                         flush_i
);

  localparam int unsigned CW = RRF_SEL + 1;

  logic [RRF_SEL-1:0]  head, tail, head_nx, tail_nx, head_p1;
  logic [CW-1:0]       used, used_nx, free;
  logic [RRF_NUM-1:0]  valid, valid_nx;
  logic [DATA_LEN-1:0] data [RRF_NUM];

  logic [1:0] alloc_req, com_req, alloc_cnt, com_cnt;
  logic       grant;

  // Request decode, grant and commit count (illegal alloc 3 means no request)
  always_comb begin
    alloc_req = (alloc_num_i == 2'd3) ? 2'd0 : alloc_num_i;
    com_req   = (com_num_i == 2'd3) ? 2'd2 : com_num_i;
    free      = CW'(RRF_NUM) - used;
    grant     = !flush_i && (free >= CW'(alloc_req));
    alloc_cnt = grant ? alloc_req : 2'd0;
    com_cnt   = (used < CW'(com_req)) ? used[1:0] : com_req;
  end

  assign alloc_stall_o = (alloc_req != 2'd0) && !grant;
  assign alloc_tag0_o  = tail;
  assign alloc_tag1_o  = tail + RRF_SEL'(1);
  assign free_cnt_o    = free;
  assign head_p1       = head + RRF_SEL'(1);

  // Pointer and occupancy next state; flush rewinds tail to the post-commit head
  always_comb begin
    head_nx = head + RRF_SEL'(com_cnt);
    tail_nx = tail + RRF_SEL'(alloc_cnt);
    used_nx = used + CW'(alloc_cnt) - CW'(com_cnt);
    if (flush_i) begin
      tail_nx = head_nx;
      used_nx = '0;
    end
  end

  // Valid next state: writeback sets, then commit clears, then allocation clears
  always_comb begin
    valid_nx = valid;
    if (!flush_i) begin
      for (int p = 0; p < int'(WB_PORTS); p++) begin
        if (wb_we_i[p]) valid_nx[wb_tag_i[p*RRF_SEL +: RRF_SEL]] = 1'b1;
      end
    end
    if (com_cnt != 2'd0) valid_nx[head] = 1'b0;
    if (com_cnt == 2'd2) valid_nx[head_p1] = 1'b0;
    if (alloc_cnt != 2'd0) valid_nx[tail] = 1'b0;
    if (alloc_cnt == 2'd2) valid_nx[alloc_tag1_o] = 1'b0;
    if (flush_i) valid_nx = '0;
  end

  // Control state
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head  <= '0;
      tail  <= '0;
      used  <= '0;
      valid <= '0;
    end else begin
      head  <= head_nx;
      tail  <= tail_nx;
      used  <= used_nx;
      valid <= valid_nx;
    end
  end

  // Data array, not reset; later ports overwrite earlier ones on a tag clash
  always_ff @(posedge clk_i) begin
    if (!flush_i) begin
      for (int p = 0; p < int'(WB_PORTS); p++) begin
        if (wb_we_i[p]) data[wb_tag_i[p*RRF_SEL +: RRF_SEL]] <= wb_data_i[p*DATA_LEN +: DATA_LEN];
      end
    end
  end

  // Read ports: array if valid, else lowest-index matching writeback, else stale
  always_comb begin
    rd_data_o  = '0;
    rd_valid_o = '0;
    for (int r = 0; r < int'(RD_PORTS); r++) begin
      logic [RRF_SEL-1:0] t;
      t = rd_tag_i[r*RRF_SEL +: RRF_SEL];
      rd_data_o[r*DATA_LEN +: DATA_LEN] = data[t];
      rd_valid_o[r] = valid[t];
      if (!valid[t]) begin
        for (int p = int'(WB_PORTS) - 1; p >= 0; p--) begin
          if (wb_we_i[p] && (wb_tag_i[p*RRF_SEL +: RRF_SEL] == t)) begin
            rd_data_o[r*DATA_LEN +: DATA_LEN] = wb_data_i[p*DATA_LEN +: DATA_LEN];
            rd_valid_o[r] = 1'b1;
          end
        end
      end
    end
  end

  // Commit view: only entries inside the allocated window report valid
  assign com_data0_o = data[head];
  assign com_data1_o = data[head_p1];
  assign com_valid_o = {valid[head_p1] && (used >= CW'(2)), valid[head] && (used != '0)};

endmodule

// File: tb/tb_rrf_freelist_mp.sv
// Directed bench for rrf_freelist_mp: vector table for allocation, then
// hand-written sequences for bypass, full, wrap, flush and async reset.
module tb_rrf_freelist_mp;

  localparam int unsigned N  = 64;
  localparam int unsigned S  = 6;
  localparam int unsigned D  = 32;
  localparam int unsigned WP = 5;
  localparam int unsigned RP = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [1:0]      alloc_num;
  logic            alloc_stall;
  logic [S-1:0]    alloc_tag0, alloc_tag1;
  logic [S:0]      free_cnt;
  logic [WP-1:0]   wb_we;
  logic [WP*S-1:0] wb_tag;
  logic [WP*D-1:0] wb_data;
  logic [RP*S-1:0] rd_tag;
  logic [RP*D-1:0] rd_data;
  logic [RP-1:0]   rd_valid;
  logic [1:0]      com_num;
  logic [D-1:0]    com_data0, com_data1;
  logic [1:0]      com_valid;
  logic            flush;

  int n_chk  = 0;
  int n_fail = 0;

  rrf_freelist_mp dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .alloc_num_i(alloc_num), .alloc_stall_o(alloc_stall),
    .alloc_tag0_o(alloc_tag0), .alloc_tag1_o(alloc_tag1), .free_cnt_o(free_cnt),
    .wb_we_i(wb_we), .wb_tag_i(wb_tag), .wb_data_i(wb_data),
    .rd_tag_i(rd_tag), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .com_num_i(com_num), .com_data0_o(com_data0), .com_data1_o(com_data1),
    .com_valid_o(com_valid), .flush_i(flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] an;
    logic [S-1:0] t0;
    logic [S-1:0] t1;
    logic [S:0] fr;
    logic st;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    alloc_num = 2'd0;
    com_num   = 2'd0;
    flush     = 1'b0;
    wb_we     = '0;
    wb_tag    = '0;
    wb_data   = '0;
  endtask

  task automatic set_wb(input int p, input logic [S-1:0] t, input logic [D-1:0] d);
    wb_we[p] = 1'b1;
    wb_tag[p*S +: S] = t;
    wb_data[p*D +: D] = d;
  endtask

  function automatic logic [D-1:0] rdd(input int r);
    return rd_data[r*D +: D];
  endfunction

  initial begin
    vecs[0] = '{2'd2, 6'd0, 6'd1, 7'd64, 1'b0};
    vecs[1] = '{2'd2, 6'd2, 6'd3, 7'd62, 1'b0};
    vecs[2] = '{2'd2, 6'd4, 6'd5, 7'd60, 1'b0};
    vecs[3] = '{2'd0, 6'd6, 6'd7, 7'd58, 1'b0};
    vecs[4] = '{2'd3, 6'd6, 6'd7, 7'd58, 1'b0};

    clr();
    rd_tag    = '0;
    reset_n   = 1'b0;
    alloc_num = 2'd2;
    #3;
    chk("rst_tag0", 64'(alloc_tag0), 64'd0);
    chk("rst_tag1", 64'(alloc_tag1), 64'd1);
    chk("rst_free", 64'(free_cnt), 64'd64);
    chk("rst_stall", 64'(alloc_stall), 64'd0);
    chk("rst_com_valid", 64'(com_valid), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    clr();
    step();

    // allocation vectors: checked before the edge, then clocked
    for (int i = 0; i < 5; i++) begin
      alloc_num = vecs[i].an;
      #1;
      chk("vec_tag0", 64'(alloc_tag0), 64'(vecs[i].t0));
      chk("vec_tag1", 64'(alloc_tag1), 64'(vecs[i].t1));
      chk("vec_free", 64'(free_cnt), 64'(vecs[i].fr));
      chk("vec_stall", 64'(alloc_stall), 64'(vecs[i].st));
      step();
    end
    clr();
    rd_tag[0 +: S] = 6'd3;
    #1;
    chk("tag3_not_valid", 64'(rd_valid[0]), 64'd0);

    // bypass from port 4; disabled port 0 carrying tag 3 must not match
    set_wb(4, 6'd3, 32'hDEADBEEF);
    set_wb(0, 6'd3, 32'h11111111);
    wb_we[0] = 1'b0;
    rd_tag[S +: S] = 6'd4;
    #1;
    chk("bypass_data", 64'(rdd(0)), 64'hDEADBEEF);
    chk("bypass_valid", 64'(rd_valid[0]), 64'd1);
    chk("no_match_valid", 64'(rd_valid[1]), 64'd0);
    step();
    clr();
    #1;
    chk("array_data", 64'(rdd(0)), 64'hDEADBEEF);
    chk("array_valid", 64'(rd_valid[0]), 64'd1);

    // two writebacks to tag 5: lowest port bypasses, highest port is stored
    set_wb(1, 6'd5, 32'hAAAA0001);
    set_wb(3, 6'd5, 32'hBBBB0003);
    rd_tag[2*S +: S] = 6'd5;
    #1;
    chk("bypass_lowest", 64'(rdd(2)), 64'hAAAA0001);
    step();
    clr();
    #1;
    chk("store_highest", 64'(rdd(2)), 64'hBBBB0003);
    chk("store_valid", 64'(rd_valid[2]), 64'd1);

    // fill to 63 used
    alloc_num = 2'd2;
    for (int i = 0; i < 28; i++) step();
    alloc_num = 2'd1;
    step();
    alloc_num = 2'd2;
    #1;
    chk("full_stall2", 64'(alloc_stall), 64'd1);
    chk("free_1", 64'(free_cnt), 64'd1);
    step();
    chk("tail_held", 64'(alloc_tag0), 64'd63);
    alloc_num = 2'd1;
    #1;
    chk("last_grant", 64'(alloc_stall), 64'd0);
    step();
    chk("free_0", 64'(free_cnt), 64'd0);
    chk("tail_wrap", 64'(alloc_tag0), 64'd0);
    com_num = 2'd2;
    #1;
    chk("full_commit_stall", 64'(alloc_stall), 64'd1);
    step();
    chk("free_after_commit", 64'(free_cnt), 64'd2);
    chk("tail_after_stall", 64'(alloc_tag0), 64'd0);

    // drain head to 62, flush so tail = head = 62
    alloc_num = 2'd0;
    for (int i = 0; i < 30; i++) step();
    com_num = 2'd0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_tail62", 64'(alloc_tag0), 64'd62);
    chk("flush_free", 64'(free_cnt), 64'd64);
    alloc_num = 2'd1;
    step();
    alloc_num = 2'd2;
    #1;
    chk("wrap_tag0", 64'(alloc_tag0), 64'd63);
    chk("wrap_tag1", 64'(alloc_tag1), 64'd0);
    step();
    clr();
    set_wb(0, 6'd62, 32'h000000A0);
    set_wb(1, 6'd63, 32'h000000A1);
    set_wb(2, 6'd0, 32'h000000A2);
    step();
    clr();
    #1;
    chk("com_data0", 64'(com_data0), 64'hA0);
    chk("com_data1", 64'(com_data1), 64'hA1);
    chk("com_valid11", 64'(com_valid), 64'd3);
    com_num = 2'd2;
    step();
    com_num = 2'd0;
    #1;
    chk("head0_data", 64'(com_data0), 64'hA2);
    chk("com_valid01", 64'(com_valid), 64'd1);

    // allocation and writeback to tag 1 in the same cycle: alloc wins valid
    alloc_num = 2'd1;
    set_wb(0, 6'd1, 32'h00000077);
    step();
    clr();
    rd_tag[3*S +: S] = 6'd1;
    #1;
    chk("alloc_wins_valid", 64'(rd_valid[3]), 64'd0);
    chk("alloc_wb_data", 64'(rdd(3)), 64'h77);

    // commit more than used is clamped
    com_num = 2'd1;
    step();
    com_num = 2'd2;
    step();
    com_num = 2'd0;
    #1;
    chk("clamp_free", 64'(free_cnt), 64'd64);
    chk("clamp_tail", 64'(alloc_tag0), 64'd2);
    chk("clamp_com_valid", 64'(com_valid), 64'd0);

    // flush with 10 in use and a same-cycle commit of 1
    alloc_num = 2'd2;
    for (int i = 0; i < 5; i++) step();
    clr();
    set_wb(0, 6'd2, 32'h12);
    set_wb(1, 6'd3, 32'h13);
    step();
    clr();
    #1;
    chk("pre_flush_free", 64'(free_cnt), 64'd54);
    flush = 1'b1;
    com_num = 2'd1;
    alloc_num = 2'd2;
    set_wb(0, 6'd5, 32'h15);
    #1;
    chk("flush_stall", 64'(alloc_stall), 64'd1);
    step();
    clr();
    rd_tag = {6'd5, 6'd4, 6'd3, 6'd2};
    #1;
    chk("flush_head", 64'(alloc_tag0), 64'd3);
    chk("flush_free64", 64'(free_cnt), 64'd64);
    chk("flush_rd_valid", 64'(rd_valid), 64'd0);

    // asynchronous reset mid-cycle
    alloc_num = 2'd2;
    for (int i = 0; i < 3; i++) step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_free", 64'(free_cnt), 64'd64);
    chk("async_tag0", 64'(alloc_tag0), 64'd0);
    chk("async_tag1", 64'(alloc_tag1), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
